ysyx_25040111_axi_sram: RTL
===========================

// Module: ysyx_25040111_axi_sram
// PURPOSE
//  AXI4 single-beat responder (slave) backed by an on-chip word array; the memory end for the LSU master.
//  Independent read and write channels, programmable response latency, byte-strobe writes.
//  Bench and SoC-less target; out-of-range or burst requests get SLVERR.
// PARAMETERS
//  ADDR_BASE    32'h8000_0000  byte address of word 0
//  DEPTH_WORDS  1024           array depth in 32-bit words (power of 2)
//  RD_LAT       2              cycles from AR handshake to rvalid (>=1)
//  WR_LAT       1              cycles from last of AW/W handshake to bvalid (>=1)
// PORTS
//  clk      in   1   clock
//  rst      in   1   synchronous active-high reset
//  awvalid  in   1   write address valid
//  awready  out  1   write address ready
//  awaddr   in   32  write byte address
//  awid     in   4   write id
//  awlen    in   8   burst length-1; must be 0
//  wvalid   in   1   write data valid
//  wready   out  1   write data ready
//  wdata    in   32  write data, lane-aligned
//  wstrb    in   4   byte enables
//  wlast    in   1   last beat; ignored (single beat)
//  bvalid   out  1   write response valid
//  bready   in   1   write response ready
//  bresp    out  2   00 OKAY, 10 SLVERR
//  bid      out  4   echo of captured awid
//  arvalid  in   1   read address valid
//  arready  out  1   read address ready
//  araddr   in   32  read byte address
//  arid     in   4   read id
//  arlen    in   8   burst length-1; must be 0
//  rvalid   out  1   read data valid
//  rready   in   1   read data ready
//  rdata    out  32  full aligned word; 0 on error
//  rresp    out  2   00 OKAY, 10 SLVERR
//  rlast    out  1   equals rvalid
//  rid      out  4   echo of captured arid
// BEHAVIOUR
//  Reset: all FSMs idle; arready=awready=wready=1 in cycle after rst drops; all other outputs 0. Array not cleared.
//  Index = (addr-ADDR_BASE)>>2, addr[1:0] ignored. err = addr outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS) or len!=0.
//  Read FSM R_IDLE->R_WAIT->R_RESP->R_IDLE. R_IDLE: arready=1; on arvalid&arready capture addr/id/err, go R_WAIT.
//   R_WAIT: counter from RD_LAT-1 down to 0; at 0, sample array into rdata reg, go R_RESP.
//   R_RESP: rvalid=1, rdata/rresp/rid stable until rready; on handshake return R_IDLE, arready=1 next cycle.
//   Handshake cycle N -> rvalid first high in N+RD_LAT. Back-to-back throughput: one read per RD_LAT+1 cycles.
//  Write FSM W_IDLE->W_WAIT->W_RESP->W_IDLE. AW and W accepted independently, either order or same cycle;
//   each ready drops after its handshake. When both captured: enter W_WAIT with WR_LAT-1 countdown.
//   At 0: if !err commit bytes where wstrb[i]=1; go W_RESP. W_RESP: bvalid=1 until bready; then both readies=1.
//  err: no array write; rdata=0; resp=2'b10. id still echoed.
//  Same-cycle write commit and read sample to same index: read returns post-write (bypassed) data.
//  Read and write channels never block each other.
//  rst during any state: return idle next cycle, pending write discarded (no commit), valids drop.
//  Protocol: valid outputs never deassert before handshake; payload stable while valid && !ready.
// TESTING
//  Reset -> cycle after rst low: arready=awready=wready=1, rvalid=bvalid=0.
//  AW 0x8000_0004 + W 0xDEADBEEF strb 1111 same cycle, bready=1 -> bvalid at +WR_LAT, bresp=00; then read 0x8000_0004 -> rdata 0xDEADBEEF at +RD_LAT.
//  W before AW (3 cycles apart), wdata 0x0000_AB00 strb 0010 over 0x11223344 -> readback 0x1122AB44.
//  Read 0x7FFF_FFFC and arlen=1 -> rresp=10, rdata=0, rid echoed; write to 0x8000_1000 (DEPTH 1024) -> bresp=10, array unchanged.
//  Hold rready=0 for 5 cycles -> rvalid/rdata/rid stable, arready=0; release -> rvalid drops next cycle.
//  Assert rst while in W_WAIT -> no array update (readback old value), bvalid stays 0.

Source files
------------

// File: rtl/ysyx_25040111_axi_sram.sv
// Single-beat AXI4 responder over an on-chip word array with programmable read/write latency.
// Out-of-range addresses and bursts get SLVERR; reads and writes run on independent FSMs.
module ysyx_25040111_axi_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned WR_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid
);
    localparam int unsigned IW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
    typedef enum logic [1:0] {WIdle, WWait, WResp} w_state_e;

    logic [31:0] mem [DEPTH_WORDS];

    r_state_e    r_state_q;
    logic [7:0]  r_cnt_q;
    logic [IW-1:0] r_idx_q;
    logic        r_err_q;
    logic [3:0]  rid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    w_state_e    w_state_q;
    logic [7:0]  w_cnt_q;
    logic        aw_got_q, w_got_q;
    logic [IW-1:0] aw_idx_q;
    logic        aw_err_q;
    logic [3:0]  bid_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q;

    // wlast carries no information for single-beat transfers.
    logic unused_wlast;
    assign unused_wlast = wlast;

    logic [31:0]   ar_off, aw_off;
    logic          ar_err, aw_err;
    logic [IW-1:0] ar_idx, aw_idx;
    logic          ar_hs, aw_hs, w_hs;

    assign ar_off = araddr - ADDR_BASE;
    assign aw_off = awaddr - ADDR_BASE;
    // Subtraction wraps below the base, so one unsigned compare covers both bounds.
    assign ar_err = (ar_off >= SPAN) || (arlen != 8'd0);
    assign aw_err = (aw_off >= SPAN) || (awlen != 8'd0);
    assign ar_idx = ar_off[IW+1:2];
    assign aw_idx = aw_off[IW+1:2];

    assign arready = (r_state_q == RIdle);
    assign awready = (w_state_q == WIdle) && !aw_got_q;
    assign wready  = (w_state_q == WIdle) && !w_got_q;
    assign ar_hs   = arvalid && arready;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    logic          w_both, wr_go, wr_err, wr_commit;
    logic [IW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;

    assign w_both = (w_state_q == WIdle) && (aw_got_q || aw_hs) && (w_got_q || w_hs);
    assign wr_go  = (w_both && (WR_LAT == 1)) || ((w_state_q == WWait) && (w_cnt_q <= 8'd1));

    always_comb begin
        wr_idx  = aw_idx_q;
        wr_err  = aw_err_q;
        wr_data = wdata_q;
        wr_strb = wstrb_q;
        if (w_state_q == WIdle) begin
            if (!aw_got_q) begin
                wr_idx = aw_idx;
                wr_err = aw_err;
            end
            if (!w_got_q) begin
                wr_data = wdata;
                wr_strb = wstrb;
            end
        end
    end

    assign wr_commit = wr_go && !wr_err && !rst;

    logic          rd_sample, rd_err;
    logic [IW-1:0] rd_idx;
    logic [31:0]   rd_word;

    assign rd_sample = (ar_hs && (RD_LAT == 1)) || ((r_state_q == RWait) && (r_cnt_q <= 8'd1));
    assign rd_idx    = (r_state_q == RIdle) ? ar_idx : r_idx_q;
    assign rd_err    = (r_state_q == RIdle) ? ar_err : r_err_q;

    // A commit landing on the sampled word in the same cycle is forwarded into the read.
    always_comb begin
        rd_word = mem[rd_idx];
        if (wr_commit && (wr_idx == rd_idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RIdle;
            r_cnt_q   <= 8'd0;
            r_idx_q   <= '0;
            r_err_q   <= 1'b0;
            rid_q     <= 4'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            w_state_q <= WIdle;
            w_cnt_q   <= 8'd0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_idx_q  <= '0;
            aw_err_q  <= 1'b0;
            bid_q     <= 4'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            bresp_q   <= 2'b00;
        end else begin
            if (rd_sample) begin
                rdata_q <= rd_err ? 32'd0 : rd_word;
                rresp_q <= rd_err ? 2'b10 : 2'b00;
            end
            unique case (r_state_q)
                RIdle: begin
                    if (ar_hs) begin
                        r_idx_q <= ar_idx;
                        r_err_q <= ar_err;
                        rid_q   <= arid;
                        r_cnt_q <= 8'(RD_LAT - 1);
                        r_state_q <= rd_sample ? RResp : RWait;
                    end
                end
                RWait: begin
                    if (rd_sample) r_state_q <= RResp;
                    else           r_cnt_q   <= r_cnt_q - 8'd1;
                end
                RResp: begin
                    if (rready) r_state_q <= RIdle;
                end
                default: r_state_q <= RIdle;
            endcase

            unique case (w_state_q)
                WIdle: begin
                    if (aw_hs) begin
                        aw_got_q <= 1'b1;
                        aw_idx_q <= aw_idx;
                        aw_err_q <= aw_err;
                        bid_q    <= awid;
                    end
                    if (w_hs) begin
                        w_got_q <= 1'b1;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                    end
                    if (w_both) begin
                        aw_got_q <= 1'b0;
                        w_got_q  <= 1'b0;
                        w_cnt_q  <= 8'(WR_LAT - 1);
                        if (wr_go) begin
                            bresp_q   <= wr_err ? 2'b10 : 2'b00;
                            w_state_q <= WResp;
                        end else begin
                            w_state_q <= WWait;
                        end
                    end
                end
                WWait: begin
                    if (wr_go) begin
                        bresp_q   <= wr_err ? 2'b10 : 2'b00;
                        w_state_q <= WResp;
                    end else begin
                        w_cnt_q <= w_cnt_q - 8'd1;
                    end
                end
                WResp: begin
                    if (bready) w_state_q <= WIdle;
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    assign rvalid = (r_state_q == RResp);
    assign rlast  = rvalid;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rid    = rid_q;
    assign bvalid = (w_state_q == WResp);
    assign bresp  = bresp_q;
    assign bid    = bid_q;

endmodule
